// File: rtl/sdram_bank_cmd_issuer.sv
// Per-bank precharge/activate initiator: classifies each column request against the
// bank tracker state, emits the needed pulses, then presents one column command.
module sdram_bank_cmd_issuer #(
  parameter int ROW_WIDTH       = 14,
  parameter int COL_WIDTH       = 10,
  parameter int NUM_GROUPS      = 2,
  parameter int BANKS_PER_GROUP = 2,
  parameter int BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
  parameter int BANK_WIDTH      = $clog2(BANKS),
  parameter int CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [BANK_WIDTH-1:0]           req_bank,
  input  logic [ROW_WIDTH-1:0]            req_row,
  input  logic [COL_WIDTH-1:0]            req_col,
  output logic [BANKS-1:0]                precharge,
  output logic [BANKS-1:0]                activate,
  output logic [ROW_WIDTH-1:0]            row_address,
  input  logic [BANKS-1:0][ROW_WIDTH-1:0] active_row_in,
  input  logic [BANKS-1:0]                active_bank,
  input  logic [BANKS-1:0]                ready_to_access,
  input  logic [BANKS-1:0]                blocked,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic                            cmd_write,
  output logic [BANK_WIDTH-1:0]           cmd_bank,
  output logic [COL_WIDTH-1:0]            cmd_col,
  output logic [CNT_WIDTH-1:0]            hit_cnt,
  output logic [CNT_WIDTH-1:0]            empty_cnt,
  output logic [CNT_WIDTH-1:0]            conflict_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECIDE    = 3'd1,
    PRECHARGE = 3'd2,
    WAIT_PRE  = 3'd3,
    ACTIVATE  = 3'd4,
    WAIT_ACT  = 3'd5,
    ISSUE     = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  logic   bank_free;
  logic   row_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [BANKS-1:0] bank_onehot(input logic [BANK_WIDTH-1:0] b);
    bank_onehot    = '0;
    bank_onehot[b] = 1'b1;
  endfunction

  assign req_ready = (state == IDLE);
  // cmd_bank and row_address hold the accepted request from acceptance onward
  assign bank_free = !blocked[cmd_bank] && ready_to_access[cmd_bank];
  assign row_hit   = active_bank[cmd_bank] && ready_to_access[cmd_bank] &&
                     (active_row_in[cmd_bank] == row_address);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      precharge    <= '0;
      activate     <= '0;
      row_address  <= '0;
      cmd_valid    <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_bank     <= '0;
      cmd_col      <= '0;
      hit_cnt      <= '0;
      empty_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      // pulses last exactly one cycle: the state that is entered with them set
      precharge <= '0;
      activate  <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_write   <= req_write;
            cmd_bank    <= req_bank;
            cmd_col     <= req_col;
            row_address <= req_row;
            state       <= DECIDE;
          end
        end
        DECIDE: begin
          if (blocked[cmd_bank]) begin
            state <= DECIDE;
          end else if (row_hit) begin
            hit_cnt   <= sat_inc(hit_cnt);
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (active_bank[cmd_bank]) begin
            conflict_cnt <= sat_inc(conflict_cnt);
            precharge    <= bank_onehot(cmd_bank);
            state        <= PRECHARGE;
          end else begin
            empty_cnt <= sat_inc(empty_cnt);
            activate  <= bank_onehot(cmd_bank);
            state     <= ACTIVATE;
          end
        end
        PRECHARGE: state <= WAIT_PRE;
        WAIT_PRE: begin
          if (bank_free) begin
            activate <= bank_onehot(cmd_bank);
            state    <= ACTIVATE;
          end
        end
        ACTIVATE: state <= WAIT_ACT;
        WAIT_ACT: begin
          if (bank_free) begin
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bank_cmd_issuer.sv
// Directed bench for sdram_bank_cmd_issuer with a behavioural bank-state tracker
// (PRE=5, ACT=8: blocked for latency+1 cycles after each pulse).
module tb_sdram_bank_cmd_issuer;
  localparam int PRE = 5;
  localparam int ACT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trk_rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_write = 1'b0;
  logic [1:0] req_bank = 2'd0;
  logic [13:0] req_row = 14'd0;
  logic [9:0] req_col = 10'd0;
  logic [3:0] precharge, activate;
  logic [13:0] row_address;
  logic [3:0][13:0] trk_row;
  logic [3:0] trk_open;
  logic [3:0][4:0] trk_cnt;
  logic [3:0] trk_blk, ext_blk, blocked, ready_to_access;
  logic cmd_valid;
  logic cmd_ready = 1'b1;
  logic cmd_write;
  logic [1:0] cmd_bank;
  logic [9:0] cmd_col;
  logic [15:0] hit_cnt, empty_cnt, conflict_cnt;

  int total = 0;
  int bad = 0;

  sdram_bank_cmd_issuer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .precharge(precharge), .activate(activate), .row_address(row_address),
    .active_row_in(trk_row), .active_bank(trk_open), .ready_to_access(ready_to_access),
    .blocked(blocked), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_bank(cmd_bank), .cmd_col(cmd_col),
    .hit_cnt(hit_cnt), .empty_cnt(empty_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // tracker model: a pulse opens/closes the row and starts the latency window
  always @(posedge clk or posedge trk_rst) begin
    if (trk_rst) begin
      trk_cnt  <= '0;
      trk_open <= '0;
      trk_row  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (activate[i]) begin
          trk_cnt[i]  <= 5'(ACT + 1);
          trk_open[i] <= 1'b1;
          trk_row[i]  <= row_address;
        end else if (precharge[i]) begin
          trk_cnt[i]  <= 5'(PRE + 1);
          trk_open[i] <= 1'b0;
        end else if (trk_cnt[i] != 5'd0) begin
          trk_cnt[i] <= trk_cnt[i] - 5'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) trk_blk[i] = (trk_cnt[i] != 5'd0);
  end
  assign blocked         = trk_blk | ext_blk;
  assign ready_to_access = ~blocked;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request (caller sits at a negedge) and watch it until cmd_valid.
  // Cycle numbers are relative to the acceptance cycle (0); -1 means never seen.
  task automatic run_req(input logic w, input logic [1:0] bk, input logic [13:0] rw,
                         input logic [9:0] cl, input int blk_n,
                         output int pre_c, output int act_c, output int cv_c,
                         output int dec_c, output logic [3:0] pre_v,
                         output logic [3:0] act_v, output logic [13:0] row_act,
                         output int viol);
    int guard = 0;
    int start_sum;
    pre_c = -1; act_c = -1; cv_c = -1; dec_c = -1; viol = 0;
    pre_v = 4'd0; act_v = 4'd0; row_act = 14'd0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start_sum = int'(hit_cnt) + int'(empty_cnt) + int'(conflict_cnt);
    req_valid = 1'b1; req_write = w; req_bank = bk; req_row = rw; req_col = cl;
    if (blk_n > 0) ext_blk[bk] = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == blk_n) ext_blk = 4'd0;
      if (precharge != 4'd0 && pre_c < 0) begin pre_c = n; pre_v = precharge; end
      if (activate != 4'd0 && act_c < 0) begin
        act_c = n; act_v = activate; row_act = row_address;
      end
      if (((precharge | activate) & blocked) != 4'd0) viol++;
      if (precharge != 4'd0 && activate != 4'd0) viol++;
      if ($countones(precharge) > 1 || $countones(activate) > 1) viol++;
      if (dec_c < 0 && (int'(hit_cnt) + int'(empty_cnt) + int'(conflict_cnt)) != start_sum)
        dec_c = n;
      if (cmd_valid) begin
        cv_c = n;
        break;
      end
    end
  endtask

  int pre_c, act_c, cv_c, dec_c, viol;
  logic [3:0] pre_v, act_v;
  logic [13:0] row_act;

  initial begin
    ext_blk = 4'd0;
    #12;
    rst = 1'b0; trk_rst = 1'b0;
    @(negedge clk);
    check("reset_outs", {precharge, activate, cmd_valid, cmd_write, cmd_bank, cmd_col, row_address}, 64'd0);
    check("reset_cnts", {hit_cnt, empty_cnt, conflict_cnt}, 64'd0);
    check("reset_ready", req_ready, 64'd1);

    // 1: row empty
    run_req(1'b0, 2'd1, 14'h123, 10'h010, 0, pre_c, act_c, cv_c, dec_c, pre_v, act_v, row_act, viol);
    check("empty_pre_c", pre_c, -1);
    check("empty_act_c", act_c, 2);
    check("empty_act_v", act_v, 4'b0010);
    check("empty_row", row_act, 14'h123);
    check("empty_cv_c", cv_c, ACT + 5);
    check("empty_cmd", {cmd_write, cmd_bank, cmd_col}, {1'b0, 2'd1, 10'h010});
    check("empty_dec_c", dec_c, 2);
    check("empty_viol", viol, 0);
    check("empty_cnts", {hit_cnt, empty_cnt, conflict_cnt}, {16'd0, 16'd1, 16'd0});

    // 2: row hit
    run_req(1'b1, 2'd1, 14'h123, 10'h020, 0, pre_c, act_c, cv_c, dec_c, pre_v, act_v, row_act, viol);
    check("hit_pulses", {pre_c, act_c}, {-32'sd1, -32'sd1});
    check("hit_cv_c", cv_c, 2);
    check("hit_cmd", {cmd_write, cmd_bank, cmd_col}, {1'b1, 2'd1, 10'h020});
    check("hit_cnts", {hit_cnt, empty_cnt, conflict_cnt}, {16'd1, 16'd1, 16'd0});

    // 3: row conflict
    run_req(1'b0, 2'd1, 14'h055, 10'h030, 0, pre_c, act_c, cv_c, dec_c, pre_v, act_v, row_act, viol);
    check("conf_pre_c", pre_c, 2);
    check("conf_pre_v", pre_v, 4'b0010);
    check("conf_act_c", act_c, PRE + 5);
    check("conf_act_v", act_v, 4'b0010);
    check("conf_row", row_act, 14'h055);
    check("conf_cv_c", cv_c, PRE + ACT + 8);
    check("conf_viol", viol, 0);
    check("conf_cnts", {hit_cnt, empty_cnt, conflict_cnt}, {16'd1, 16'd1, 16'd1});

    // 4: backpressure on a row hit
    @(negedge clk);
    cmd_ready = 1'b0;
    run_req(1'b1, 2'd1, 14'h055, 10'h3A5, 0, pre_c, act_c, cv_c, dec_c, pre_v, act_v, row_act, viol);
    check("bp_cv_c", cv_c, 2);
    for (int k = 0; k < 6; k++) begin
      check("bp_hold", {cmd_valid, req_ready, cmd_write, cmd_bank, cmd_col}, {1'b1, 1'b0, 1'b1, 2'd1, 10'h3A5});
      @(negedge clk);
    end
    check("bp_last", {cmd_valid, req_ready, cmd_col}, {1'b1, 1'b0, 10'h3A5});
    cmd_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {cmd_valid, req_ready}, {1'b0, 1'b1});
    check("bp_hit_cnt", hit_cnt, 16'd2);

    // 5: reset while waiting on activate latency
    req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd3; req_row = 14'h0AA; req_col = 10'h001;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_outs", {precharge, activate, cmd_valid, cmd_write, cmd_bank, cmd_col, row_address}, 64'd0);
    check("rst_cnts", {hit_cnt, empty_cnt, conflict_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", req_ready, 64'd1);
    @(negedge clk);
    run_req(1'b0, 2'd3, 14'h0AA, 10'h002, 0, pre_c, act_c, cv_c, dec_c, pre_v, act_v, row_act, viol);
    check("rst_next_cv_c", cv_c, 6);
    check("rst_next_pulses", {pre_c, act_c}, {-32'sd1, -32'sd1});
    check("rst_next_cnts", {hit_cnt, empty_cnt, conflict_cnt}, {16'd1, 16'd0, 16'd0});
    check("rst_next_cmd", {cmd_bank, cmd_col}, {2'd3, 10'h002});

    // 6: externally blocked bank stalls DECIDE
    run_req(1'b1, 2'd2, 14'h200, 10'h044, 10, pre_c, act_c, cv_c, dec_c, pre_v, act_v, row_act, viol);
    check("blk_dec_c", dec_c, 11);
    check("blk_act_c", act_c, 11);
    check("blk_act_v", act_v, 4'b0100);
    check("blk_cv_c", cv_c, 11 + ACT + 3);
    check("blk_viol", viol, 0);
    check("blk_cnts", {hit_cnt, empty_cnt, conflict_cnt}, {16'd1, 16'd1, 16'd0});

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_bank_cmd_issuer.md
Name: sdram_bank_cmd_issuer

Overview:
Initiator side of the per-bank precharge/activate interface. It accepts one column request at a time (bank, row, column, read/write) and reads the bank-state tracker outputs (`active_bank`, active row, `ready_to_access`, `blocked`). From these it issues the needed precharge and/or activate pulses, then presents a single column command downstream. It classifies each request as row hit, row empty or row conflict, and keeps saturating statistics counters for each class.

Parameters:
ROW_WIDTH, 14, row address bits
COL_WIDTH, 10, column address bits
NUM_GROUPS, 2, bank groups
BANKS_PER_GROUP, 2, banks per group
BANKS, NUM_GROUPS*BANKS_PER_GROUP, total banks
BANK_WIDTH, $clog2(BANKS), bank index bits
CNT_WIDTH, 16, statistics counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1=write, 0=read
req_bank  in  BANK_WIDTH  target bank
req_row  in  ROW_WIDTH  target row
req_col  in  COL_WIDTH  target column
precharge  out  BANKS  one-hot precharge pulse
activate  out  BANKS  one-hot activate pulse
row_address  out  ROW_WIDTH  row for activate
active_row_in  in  BANKS x ROW_WIDTH  open row per bank
active_bank  in  BANKS  bank has open row
ready_to_access  in  BANKS  bank not in latency window
blocked  in  BANKS  bank in precharge/activate latency
cmd_valid  out  1  column command valid
cmd_ready  in  1  downstream accepts command
cmd_write  out  1  latched req_write
cmd_bank  out  BANK_WIDTH  latched req_bank
cmd_col  out  COL_WIDTH  latched req_col
hit_cnt  out  CNT_WIDTH  row-hit count
empty_cnt  out  CNT_WIDTH  row-empty count
conflict_cnt  out  CNT_WIDTH  row-conflict count

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - Outputs cleared: precharge, activate, cmd_valid, cmd_write, cmd_bank, cmd_col, row_address, all counters.
  - req_ready=1 from reset deassertion.
- FSM states: IDLE, DECIDE, PRECHARGE, WAIT_PRE, ACTIVATE, WAIT_ACT, ISSUE.
- req_ready = (state==IDLE), combinational from state only. On acceptance, latch write/bank/row/col and go to DECIDE. Call the latched bank b.
- DECIDE (evaluated every cycle in this state):
  - blocked[b]=1: stay in DECIDE; no pulses, no counter update.
  - active_bank[b] && active_row_in[b]==row && ready_to_access[b]: row hit. hit_cnt++ and go to ISSUE.
  - active_bank[b] otherwise (open row differs): row conflict. conflict_cnt++ and go to PRECHARGE.
  - else: row empty. empty_cnt++ and go to ACTIVATE.
- PRECHARGE: precharge[b]=1 for exactly this cycle, all other bits 0; go to WAIT_PRE.
- WAIT_PRE: stay until blocked[b]==0 && ready_to_access[b]==1, then go to ACTIVATE.
- ACTIVATE: activate[b]=1 for exactly this cycle; go to WAIT_ACT.
- WAIT_ACT: stay until blocked[b]==0 && ready_to_access[b]==1, then go to ISSUE.
- row_address: registered and driven with the latched row from acceptance onward; held until the next acceptance.
- ISSUE: cmd_valid=1 with cmd_* stable. Hold until cmd_valid && cmd_ready, then go to IDLE in the next cycle.
- Pulse rules:
  - precharge and activate are never both nonzero in one cycle.
  - Neither is ever asserted while blocked[b]=1.
  - At most one bit of each is set.
- Counters saturate at all-ones and increment only on DECIDE resolution.
- Latency, with cycle 0 = acceptance cycle and tracker latencies PRE/ACT (blocked high PRE+1 / ACT+1 cycles):
  - row hit: cmd_valid first at cycle 2.
  - row empty: activate at cycle 2, cmd_valid at cycle ACT+5.
  - row conflict: precharge at cycle 2, activate at cycle PRE+5, cmd_valid at cycle PRE+ACT+8.
- No new request is accepted until the current command handshakes; there is no reordering.

Test Plan:
1. Row empty. After reset, with tracker PRE=5, ACT=8, request read bank1 row 0x123 col 0x10 → activate=4'b0010 and row_address=0x123 at cycle 2; cmd_valid at cycle 13 with cmd_bank=1, cmd_col=0x10, cmd_write=0; empty_cnt=1.
2. Row hit. Then write bank1 row 0x123 col 0x20 → no precharge/activate pulses; cmd_valid at cycle 2 with cmd_write=1; hit_cnt=1.
3. Row conflict. Then read bank1 row 0x055 → precharge=4'b0010 at cycle 2, activate=4'b0010 with row_address=0x055 at cycle 10, cmd_valid at cycle 21; conflict_cnt=1.
4. Backpressure. Hold cmd_ready=0 for 6 cycles during ISSUE → cmd_valid and cmd_* held stable and req_ready=0 throughout; handshake on cycle 7, req_ready=1 on the next cycle.
5. Reset mid-operation. Assert rst during WAIT_ACT → all outputs 0 immediately (async) and counters 0; after release req_ready=1, and the next request to the same bank is handled from DECIDE normally.
6. Blocked bank. Drive blocked[2]=1 externally for 10 cycles at acceptance of a bank2 request → FSM stays in DECIDE with no pulses and no counter change; it resolves on the first cycle with blocked[2]=0.
